// File: rtl/edge_binarize_stats.sv
`default_nettype none
// ============================================================================
//  Module   : edge_binarize_stats
//  Purpose  : Binarizes a Sobel gradient stream against a per-frame threshold,
//             tags each output pixel with raster coordinates and publishes
//             per-frame edge count (and optionally a bounding box) once per
//             frame together with a one-cycle frame_done pulse.
//  Options  : EDGE_BBOX_EN - when defined, the bounding-box accumulators and
//             outputs are built; otherwise the bbox ports are tied to 0.
//  Revision : 1.0 - initial release
// ============================================================================
module edge_binarize_stats #(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int CW           = $clog2(IMAGE_WIDTH),
    parameter int RW           = $clog2(IMAGE_HEIGHT),
    parameter int NW           = $clog2(IMAGE_WIDTH*IMAGE_HEIGHT+1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [7:0]    threshold,
    input  logic          pixel_in_valid,
    input  logic [7:0]    pixel_in,
    output logic          pixel_out_valid,
    output logic [7:0]    pixel_out,
    output logic [RW-1:0] row_out,
    output logic [CW-1:0] col_out,
    output logic          frame_done,
    output logic [NW-1:0] edge_count,
    output logic          bbox_valid,
    output logic [CW-1:0] bbox_xmin,
    output logic [CW-1:0] bbox_xmax,
    output logic [RW-1:0] bbox_ymin,
    output logic [RW-1:0] bbox_ymax
);

    localparam logic [CW-1:0] COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [NW-1:0] CNT_MAX  = '1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t        state;
    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    thr_q;
    logic [NW-1:0] acc_cnt;

    logic          at_origin;
    logic          at_last;
    logic          frame_start;
    logic          frame_last;
    logic [7:0]    thr_eff;
    logic          is_edge;
    logic [NW-1:0] cnt_base;
    logic [NW-1:0] cnt_next;

    // Frame boundary decode, effective threshold and edge decision.
    // The first pixel of a frame must see the threshold being sampled now,
    // not the stale thr_q, hence the bypass mux.
    always_comb begin
        at_origin   = (row == '0) && (col == '0);
        at_last     = (row == ROW_LAST) && (col == COL_LAST);
        frame_start = pixel_in_valid && at_origin && (state == ST_IDLE);
        frame_last  = pixel_in_valid && at_last;
        thr_eff     = frame_start ? threshold : thr_q;
        is_edge     = (pixel_in >= thr_eff);
    end

    // Count accumulator next value: restart on frame start, saturate at max.
    always_comb begin
        cnt_base = frame_start ? '0 : acc_cnt;
        cnt_next = cnt_base;
        if (is_edge && (cnt_base != CNT_MAX)) begin
            cnt_next = cnt_base + NW'(1);
        end
    end

    // Raster counters: advance on every accepted pixel, wrap at row/frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pixel_in_valid) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Frame FSM; the threshold is captured when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            thr_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        thr_q <= threshold;
                        // A one-pixel frame starts and ends on the same beat.
                        state <= frame_last ? ST_IDLE : ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (frame_last) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // One-cycle output pipeline; data holds while no pixel is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out_valid <= 1'b0;
            pixel_out       <= '0;
            row_out         <= '0;
            col_out         <= '0;
            frame_done      <= 1'b0;
        end else begin
            pixel_out_valid <= pixel_in_valid;
            frame_done      <= frame_last;
            if (pixel_in_valid) begin
                pixel_out <= is_edge ? 8'd255 : 8'd0;
                row_out   <= row;
                col_out   <= col;
            end
        end
    end

    // Edge count accumulation and publication on the last pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_cnt    <= '0;
            edge_count <= '0;
        end else if (pixel_in_valid) begin
            acc_cnt <= cnt_next;
            if (frame_last) begin
                edge_count <= cnt_next;
            end
        end
    end

`ifdef EDGE_BBOX_EN
    logic          acc_any;
    logic [CW-1:0] acc_xmin;
    logic [CW-1:0] acc_xmax;
    logic [RW-1:0] acc_ymin;
    logic [RW-1:0] acc_ymax;

    logic          any_base;
    logic          any_next;
    logic [CW-1:0] xmin_next;
    logic [CW-1:0] xmax_next;
    logic [RW-1:0] ymin_next;
    logic [RW-1:0] ymax_next;

    // Bbox next values: seeded from the frame's first pixel, then the first
    // edge of the frame overwrites the seed and later edges widen the box.
    always_comb begin
        any_base  = frame_start ? 1'b0 : acc_any;
        xmin_next = frame_start ? col : acc_xmin;
        xmax_next = frame_start ? col : acc_xmax;
        ymin_next = frame_start ? row : acc_ymin;
        ymax_next = frame_start ? row : acc_ymax;
        if (is_edge) begin
            if (!any_base) begin
                xmin_next = col;
                xmax_next = col;
                ymin_next = row;
                ymax_next = row;
            end else begin
                if (col < xmin_next) xmin_next = col;
                if (col > xmax_next) xmax_next = col;
                if (row < ymin_next) ymin_next = row;
                if (row > ymax_next) ymax_next = row;
            end
        end
        any_next = any_base | is_edge;
    end

    // Bbox accumulation and publication; an edge-free frame publishes zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_any    <= 1'b0;
            acc_xmin   <= '0;
            acc_xmax   <= '0;
            acc_ymin   <= '0;
            acc_ymax   <= '0;
            bbox_valid <= 1'b0;
            bbox_xmin  <= '0;
            bbox_xmax  <= '0;
            bbox_ymin  <= '0;
            bbox_ymax  <= '0;
        end else if (pixel_in_valid) begin
            acc_any  <= any_next;
            acc_xmin <= xmin_next;
            acc_xmax <= xmax_next;
            acc_ymin <= ymin_next;
            acc_ymax <= ymax_next;
            if (frame_last) begin
                bbox_valid <= any_next;
                bbox_xmin  <= any_next ? xmin_next : '0;
                bbox_xmax  <= any_next ? xmax_next : '0;
                bbox_ymin  <= any_next ? ymin_next : '0;
                bbox_ymax  <= any_next ? ymax_next : '0;
            end
        end
    end
`else
    // Bounding box not built: ports are constant zero.
    assign bbox_valid = 1'b0;
    assign bbox_xmin  = '0;
    assign bbox_xmax  = '0;
    assign bbox_ymin  = '0;
    assign bbox_ymax  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_edge_binarize_stats.sv
`default_nettype none
// ============================================================================
//  Module   : tb_edge_binarize_stats
//  Purpose  : Self-checking bench for edge_binarize_stats on a 4x3 image.
//             Table vectors plus randomized frames compared against a
//             frame-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_edge_binarize_stats;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int N  = W * H;
    localparam int CW = $clog2(W);
    localparam int RW = $clog2(H);
    localparam int NW = $clog2(W*H+1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [7:0]    threshold = '0;
    logic          pixel_in_valid = 1'b0;
    logic [7:0]    pixel_in = '0;
    logic          pixel_out_valid;
    logic [7:0]    pixel_out;
    logic [RW-1:0] row_out;
    logic [CW-1:0] col_out;
    logic          frame_done;
    logic [NW-1:0] edge_count;
    logic          bbox_valid;
    logic [CW-1:0] bbox_xmin;
    logic [CW-1:0] bbox_xmax;
    logic [RW-1:0] bbox_ymin;
    logic [RW-1:0] bbox_ymax;

    edge_binarize_stats #(
        .IMAGE_WIDTH (W),
        .IMAGE_HEIGHT(H)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .threshold      (threshold),
        .pixel_in_valid (pixel_in_valid),
        .pixel_in       (pixel_in),
        .pixel_out_valid(pixel_out_valid),
        .pixel_out      (pixel_out),
        .row_out        (row_out),
        .col_out        (col_out),
        .frame_done     (frame_done),
        .edge_count     (edge_count),
        .bbox_valid     (bbox_valid),
        .bbox_xmin      (bbox_xmin),
        .bbox_xmax      (bbox_xmax),
        .bbox_ymin      (bbox_ymin),
        .bbox_ymax      (bbox_ymax)
    );

    always #5 clk = ~clk;

    // Reference model state
    int       k;            // pixels accepted since reset
    int       fthr;         // threshold of the current frame
    bit       fedge [N];    // edge flags of the current frame, raster order
    int       exp_cnt, exp_bv, exp_xmin, exp_xmax, exp_ymin, exp_ymax;
    int       lpix, lrow, lcol;
    int       fd_seen, fd_exp;
    int       checks, failures;

    typedef struct {
        logic [7:0] pix;
        logic [7:0] thr;
        logic [7:0] exp_out;
    } vec_t;
    vec_t tbl [N];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_stats();
        chk("edge_count", int'(edge_count), exp_cnt);
        chk("bbox_valid", int'(bbox_valid), exp_bv);
        chk("bbox_xmin",  int'(bbox_xmin),  exp_xmin);
        chk("bbox_xmax",  int'(bbox_xmax),  exp_xmax);
        chk("bbox_ymin",  int'(bbox_ymin),  exp_ymin);
        chk("bbox_ymax",  int'(bbox_ymax),  exp_ymax);
    endtask

    // Frame statistics straight from the list of edge flags.
    task automatic compute_stats();
        int cnt, xmn, xmx, ymn, ymx;
        cnt = 0; xmn = W; xmx = -1; ymn = H; ymx = -1;
        for (int i = 0; i < N; i++) begin
            if (fedge[i]) begin
                cnt++;
                if (i % W < xmn) xmn = i % W;
                if (i % W > xmx) xmx = i % W;
                if (i / W < ymn) ymn = i / W;
                if (i / W > ymx) ymx = i / W;
            end
        end
        exp_cnt = cnt;
`ifdef EDGE_BBOX_EN
        exp_bv   = (cnt > 0) ? 1 : 0;
        exp_xmin = (cnt > 0) ? xmn : 0;
        exp_xmax = (cnt > 0) ? xmx : 0;
        exp_ymin = (cnt > 0) ? ymn : 0;
        exp_ymax = (cnt > 0) ? ymx : 0;
`else
        exp_bv = 0; exp_xmin = 0; exp_xmax = 0; exp_ymin = 0; exp_ymax = 0;
`endif
    endtask

    // Present one valid pixel at a falling edge and check the result one
    // cycle later at the next falling edge.
    task automatic push(input logic [7:0] pix, input logic [7:0] thr);
        int  r, c;
        bit  e, last;
        r = (k / W) % H;
        c = k % W;
        if (k % N == 0) fthr = int'(thr);
        e    = (int'(pix) >= fthr);
        last = (k % N == N - 1);
        fedge[k % N] = e;
        threshold      = thr;
        pixel_in       = pix;
        pixel_in_valid = 1'b1;
        @(negedge clk);
        k++;
        lpix = e ? 255 : 0;
        lrow = r;
        lcol = c;
        if (last) begin
            compute_stats();
            fd_exp++;
        end
        if (frame_done) fd_seen++;
        chk("out_valid",  int'(pixel_out_valid), 1);
        chk("pixel_out",  int'(pixel_out), lpix);
        chk("row_out",    int'(row_out), lrow);
        chk("col_out",    int'(col_out), lcol);
        chk("frame_done", int'(frame_done), last ? 1 : 0);
        check_stats();
    endtask

    // One cycle with no valid pixel: outputs hold, qualifiers low.
    task automatic idle();
        pixel_in_valid = 1'b0;
        pixel_in       = 8'($urandom);
        @(negedge clk);
        if (frame_done) fd_seen++;
        chk("idle_valid",      int'(pixel_out_valid), 0);
        chk("idle_frame_done", int'(frame_done), 0);
        chk("idle_pixel_hold", int'(pixel_out), lpix);
        chk("idle_row_hold",   int'(row_out), lrow);
        chk("idle_col_hold",   int'(col_out), lcol);
        check_stats();
    endtask

    task automatic do_reset(input int cycles);
        pixel_in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        k = 0; lpix = 0; lrow = 0; lcol = 0;
        exp_cnt = 0; exp_bv = 0; exp_xmin = 0; exp_xmax = 0; exp_ymin = 0; exp_ymax = 0;
        chk("rst_out_valid",  int'(pixel_out_valid), 0);
        chk("rst_pixel_out",  int'(pixel_out), 0);
        chk("rst_row_out",    int'(row_out), 0);
        chk("rst_col_out",    int'(col_out), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        check_stats();
        repeat (cycles) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic random_frame(input int gap_max);
        logic [7:0] thr;
        thr = 8'($urandom);
        for (int i = 0; i < N; i++) begin
            push(8'($urandom), (i == 0) ? thr : 8'($urandom));
            repeat ($urandom_range(0, gap_max)) idle();
        end
    endtask

    initial begin
        checks = 0; failures = 0; fd_seen = 0; fd_exp = 0;
        k = 0; fthr = 0; lpix = 0; lrow = 0; lcol = 0;
        exp_cnt = 0; exp_bv = 0; exp_xmin = 0; exp_xmax = 0; exp_ymin = 0; exp_ymax = 0;

        // Threshold-boundary frame: edges at (0,1),(1,0),(1,2),(2,1),(2,3)
        tbl[0]  = '{8'd99,  8'd100, 8'd0};
        tbl[1]  = '{8'd100, 8'd100, 8'd255};
        tbl[2]  = '{8'd0,   8'd100, 8'd0};
        tbl[3]  = '{8'd50,  8'd100, 8'd0};
        tbl[4]  = '{8'd101, 8'd100, 8'd255};
        tbl[5]  = '{8'd99,  8'd100, 8'd0};
        tbl[6]  = '{8'd255, 8'd100, 8'd255};
        tbl[7]  = '{8'd0,   8'd100, 8'd0};
        tbl[8]  = '{8'd98,  8'd100, 8'd0};
        tbl[9]  = '{8'd200, 8'd100, 8'd255};
        tbl[10] = '{8'd1,   8'd100, 8'd0};
        tbl[11] = '{8'd100, 8'd100, 8'd255};

        @(negedge clk);
        do_reset(3);

        // Table-driven threshold boundary frame
        for (int i = 0; i < N; i++) begin
            push(tbl[i].pix, tbl[i].thr);
            chk("tbl_pixel_out", int'(pixel_out), int'(tbl[i].exp_out));
        end
        chk("tbl_edge_count", int'(edge_count), 5);
`ifdef EDGE_BBOX_EN
        chk("tbl_bbox_valid", int'(bbox_valid), 1);
        chk("tbl_bbox_xmax",  int'(bbox_xmax), 3);
        chk("tbl_bbox_ymax",  int'(bbox_ymax), 2);
`else
        chk("tbl_bbox_valid", int'(bbox_valid), 0);
`endif
        idle();
        idle();

        // Frame with no edges
        for (int i = 0; i < N; i++) begin
            push(8'd0, 8'd1);
            chk("noedge_pixel_out", int'(pixel_out), 0);
        end
        chk("noedge_edge_count", int'(edge_count), 0);
        chk("noedge_bbox_valid", int'(bbox_valid), 0);

        // Threshold 0 and 255 extremes, back to back
        for (int i = 0; i < N; i++) push(8'($urandom), 8'd0);
        chk("thr0_edge_count", int'(edge_count), N);
        for (int i = 0; i < N; i++) push((i % 3 == 0) ? 8'd255 : 8'd254, 8'd255);
        chk("thr255_edge_count", int'(edge_count), 4);

        // Gapped input, threshold 50 then 200 after pixel 3
        for (int i = 0; i < N; i++) begin
            push((i == 5) ? 8'd120 : (i == 7) ? 8'd49 : 8'($urandom),
                 (i < 3) ? 8'd50 : 8'd200);
            if (i == 5) chk("gap_thr_kept_edge", int'(pixel_out), 255);
            if (i == 7) chk("gap_thr_kept_noedge", int'(pixel_out), 0);
            idle();
            idle();
        end

        // Back-to-back random frames, then randomly gapped frames
        random_frame(0);
        random_frame(0);
        for (int f = 0; f < 4; f++) random_frame(2);

        // Reset after 7 pixels of a frame
        for (int i = 0; i < 7; i++) push(8'($urandom), 8'd30);
        do_reset(2);
        for (int i = 0; i < N; i++) push((i == 0 || i == 10) ? 8'd90 : 8'd10, 8'd80);
        chk("postrst_edge_count", int'(edge_count), 2);
        idle();
        random_frame(1);

        chk("frame_done_pulses", fd_seen, fd_exp);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
